// File: rtl/flap_char_stepper_if.sv
// flap_char_stepper_if: target handshake, glyph ROM port and committed matrix
interface flap_char_stepper_if;
    logic        tgt_valid;
    logic        tgt_ready;
    logic [5:0]  tgt_char;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [71:0] matrix;
    logic        load;
    logic [5:0]  cur_char;
    logic        busy;
    modport master (
        output tgt_valid, tgt_char, rom_data,
        input  tgt_ready, rom_addr, matrix, load, cur_char, busy
    );
    modport slave (
        input  tgt_valid, tgt_char, rom_data,
        output tgt_ready, rom_addr, matrix, load, cur_char, busy
    );
endinterface

// File: rtl/flap_char_stepper.sv
// flap_char_stepper: split-flap style forward stepper that fetches each glyph
// from a 1-cycle ROM and commits a full 72-bit frame atomically
module flap_char_stepper #(
    parameter int NCHAR    = 40,
    parameter int TICK_DIV = 24
) (
    input logic                clk,
    input logic                reset,
    flap_char_stepper_if.slave bus
);
    localparam int CW = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] WLAST = CW'(TICK_DIV - 1);
    typedef enum logic [2:0] {IDLE, ADVANCE, FETCH, COMMIT, WAIT} state_t;
    state_t        state;
    logic [5:0]    tgt;
    logic [5:0]    cur;
    logic [3:0]    col;
    logic [CW-1:0] cnt;
    logic [63:0]   shadow;
    logic [71:0]   matrix;
    logic [8:0]    rom_addr;
    logic          load;
    assign bus.tgt_ready = state == IDLE;
    assign bus.busy      = state != IDLE;
    assign bus.rom_addr  = rom_addr;
    assign bus.matrix    = matrix;
    assign bus.load      = load;
    assign bus.cur_char  = cur;
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tgt      <= '0;
            cur      <= '0;
            col      <= '0;
            cnt      <= '0;
            shadow   <= '0;
            matrix   <= '0;
            rom_addr <= '0;
            load     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.tgt_valid) begin
                    tgt <= bus.tgt_char;
                    if (bus.tgt_char != cur && {1'b0, bus.tgt_char} < 7'(NCHAR)) state <= ADVANCE;
                end
                ADVANCE: begin
                    cur   <= (cur == 6'(NCHAR - 1)) ? '0 : cur + 6'd1;
                    col   <= '0;
                    load  <= 1'b1;
                    state <= FETCH;
                end
                // Address for column k goes out while column k-1 is captured;
                // shifting in keeps column 0 at the top of the shadow frame.
                FETCH: begin
                    if (col <= 4'd7) rom_addr <= {cur, col[2:0]};
                    if (col >= 4'd1) shadow <= {shadow[55:0], bus.rom_data};
                    col <= col + 4'd1;
                    if (col == 4'd8) state <= COMMIT;
                end
                COMMIT: begin
                    matrix <= {(cur == '0) ? 8'h00 : 8'hFF, shadow};
                    load   <= 1'b0;
                    cnt    <= '0;
                    state  <= (cur == tgt) ? IDLE : WAIT;
                end
                WAIT: begin
                    if (cnt == WLAST) state <= ADVANCE;
                    else cnt <= cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
